// File: rtl/dmem_host_loader.sv
// Host-side loader for the CPU data memory. It keeps the CPU in reset while it
// streams words in from the host, lets the CPU run for a fixed number of cycles,
// then puts the CPU back in reset and streams result words out to the host.
module dmem_host_loader #(
  parameter int unsigned N_LOAD     = 16,
  parameter int unsigned N_DUMP     = 16,
  parameter int unsigned RUN_CYCLES = 1000,
  parameter logic [31:0] LOAD_BASE  = 32'h0,
  parameter logic [31:0] DUMP_BASE  = 32'h0,
  parameter int unsigned ADDR_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        cpu_rst,
  output logic        ext_memwr_sgn,
  output logic [31:0] ext_datamem_wr,
  output logic [31:0] ext_datamem_rd,
  input  logic [31:0] read_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        busy,
  output logic        done
);

  localparam int unsigned LOAD_W = $clog2(N_LOAD + 1);
  localparam int unsigned DUMP_W = $clog2(N_DUMP + 1);
  localparam int unsigned RUN_W  = $clog2(RUN_CYCLES + 1);
  localparam logic [31:0] STEP   = 32'(ADDR_STEP);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_RUN,
    S_DUMP_ADDR,
    S_DUMP_OUT,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [LOAD_W-1:0] load_cnt_q, load_cnt_d;
  logic [DUMP_W-1:0] dump_cnt_q, dump_cnt_d;
  logic [RUN_W-1:0]  run_cnt_q, run_cnt_d;

  logic        in_ready_d;
  logic        cpu_rst_d;
  logic        memwr_d;
  logic [31:0] wr_d;
  logic [31:0] rd_d;
  logic        out_valid_d;
  logic [31:0] out_data_d;
  logic        busy_d;
  logic        done_d;

  // State, counters and all outputs are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      load_cnt_q     <= '0;
      dump_cnt_q     <= '0;
      run_cnt_q      <= '0;
      in_ready       <= 1'b0;
      cpu_rst        <= 1'b1;
      ext_memwr_sgn  <= 1'b0;
      ext_datamem_wr <= 32'h0;
      ext_datamem_rd <= 32'h0;
      out_valid      <= 1'b0;
      out_data       <= 32'h0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      state_q        <= state_d;
      load_cnt_q     <= load_cnt_d;
      dump_cnt_q     <= dump_cnt_d;
      run_cnt_q      <= run_cnt_d;
      in_ready       <= in_ready_d;
      cpu_rst        <= cpu_rst_d;
      ext_memwr_sgn  <= memwr_d;
      ext_datamem_wr <= wr_d;
      ext_datamem_rd <= rd_d;
      out_valid      <= out_valid_d;
      out_data       <= out_data_d;
      busy           <= busy_d;
      done           <= done_d;
    end
  end

  // Next-state and next-output logic; the write strobe is a one-cycle pulse per accept.
  always_comb begin
    state_d     = state_q;
    load_cnt_d  = load_cnt_q;
    dump_cnt_d  = dump_cnt_q;
    run_cnt_d   = run_cnt_q;
    in_ready_d  = in_ready;
    cpu_rst_d   = cpu_rst;
    memwr_d     = 1'b0;
    wr_d        = ext_datamem_wr;
    rd_d        = ext_datamem_rd;
    out_valid_d = out_valid;
    out_data_d  = out_data;
    busy_d      = busy;
    done_d      = done;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d    = S_LOAD;
          load_cnt_d = '0;
          in_ready_d = 1'b1;
          busy_d     = 1'b1;
          done_d     = 1'b0;
        end
      end

      S_LOAD: begin
        if (in_valid && in_ready) begin
          memwr_d    = 1'b1;
          wr_d       = in_data;
          rd_d       = LOAD_BASE + 32'(load_cnt_q) * STEP;
          load_cnt_d = load_cnt_q + LOAD_W'(1);
          if (load_cnt_q == LOAD_W'(N_LOAD - 1)) begin
            in_ready_d = 1'b0;
            state_d    = S_DRAIN;
          end
        end
      end

      // Final write is on the port this cycle; the port is parked before the CPU wakes.
      S_DRAIN: begin
        state_d   = S_RUN;
        cpu_rst_d = 1'b0;
        run_cnt_d = '0;
        wr_d      = 32'h0;
        rd_d      = 32'h0;
      end

      S_RUN: begin
        if (run_cnt_q == RUN_W'(RUN_CYCLES - 1)) begin
          state_d    = S_DUMP_ADDR;
          cpu_rst_d  = 1'b1;
          dump_cnt_d = '0;
          rd_d       = DUMP_BASE;
        end else begin
          run_cnt_d = run_cnt_q + RUN_W'(1);
        end
      end

      // Memory read is combinational from the address registered on entry.
      S_DUMP_ADDR: begin
        out_data_d  = read_data;
        out_valid_d = 1'b1;
        state_d     = S_DUMP_OUT;
      end

      S_DUMP_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          dump_cnt_d  = dump_cnt_q + DUMP_W'(1);
          if (dump_cnt_q == DUMP_W'(N_DUMP - 1)) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            rd_d    = 32'h0;
          end else begin
            state_d = S_DUMP_ADDR;
            rd_d    = ext_datamem_rd + STEP;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
